// File: rtl/sprite_char_ctrl.sv
// Player-character engine: command latch, blocked and clamped movement, walk animation,
// attack/hurt timers, and a 2-stage sprite streamer that keys out the transparent colour.
module sprite_char_ctrl #(
    parameter int         SPRITE_W     = 16,
    parameter int         SPRITE_H     = 16,
    parameter int         STEP         = 1,
    parameter int         X_MAX        = 304,
    parameter int         Y_MAX        = 224,
    parameter int         START_X      = 1,
    parameter int         START_Y      = 96,
    parameter int         ANIM_DIV     = 8,
    parameter int         ATTACK_TICKS = 16,
    parameter int         HURT_TICKS   = 32,
    parameter logic [5:0] TRANSPARENT  = 6'h3F,
    localparam int        AW           = 4 + $clog2(SPRITE_W * SPRITE_H)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          c_attack,
    input  logic          c_up,
    input  logic          c_down,
    input  logic          c_left,
    input  logic          c_right,
    input  logic          init,
    input  logic          reg_action,
    input  logic          apply_action,
    input  logic          draw,
    input  logic [1:0]    collision,
    output logic [AW-1:0] sprite_addr,
    input  logic [5:0]    sprite_q,
    output logic [8:0]    x_pos,
    output logic [7:0]    y_pos,
    output logic [8:0]    x_draw,
    output logic [7:0]    y_draw,
    output logic [5:0]    colour,
    output logic          VGA_write,
    output logic [2:0]    direction,
    output logic [1:0]    facing,
    output logic          attacking,
    output logic          hurt,
    output logic          draw_done
);
    localparam int NPIX = SPRITE_W * SPRITE_H;
    localparam int PW   = $clog2(NPIX);
    localparam int XW   = $clog2(SPRITE_W);
    localparam int MW   = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
    localparam int AKW  = $clog2(ATTACK_TICKS + 1);
    localparam int HKW  = $clog2(HURT_TICKS + 1);

    localparam logic [2:0] DIR_NONE = 3'd0, DIR_ATTACK = 3'd1, DIR_UP = 3'd2,
                           DIR_DOWN = 3'd3, DIR_LEFT = 3'd4, DIR_RIGHT = 3'd5;
    localparam logic [1:0] F_DOWN = 2'd0, F_LEFT = 2'd1, F_UP = 2'd2, F_RIGHT = 2'd3;

    logic           anim;
    logic [MW-1:0]  move_cnt;
    logic [AKW-1:0] atk_cnt;
    logic [HKW-1:0] hurt_cnt;
    logic [PW-1:0]  pix;
    logic           pix_vld;
    logic           issue;
    logic           last_pix;
    int             nx, ny;
    logic [1:0]     nface;
    logic           moved;

    assign attacking = (atk_cnt != '0);
    assign hurt      = (hurt_cnt != '0);

    // Candidate move, computed signed so clamping at 0 cannot wrap.
    always_comb begin
        nx    = int'(x_pos);
        ny    = int'(y_pos);
        nface = facing;
        case (direction)
            DIR_UP:    begin nface = F_UP;    ny = ny - STEP; end
            DIR_DOWN:  begin nface = F_DOWN;  ny = ny + STEP; end
            DIR_LEFT:  begin nface = F_LEFT;  nx = nx - STEP; end
            DIR_RIGHT: begin nface = F_RIGHT; nx = nx + STEP; end
            default: ;
        endcase
        if (collision[0]) begin
            nx = int'(x_pos);
            ny = int'(y_pos);
        end
        if (nx < 0) nx = 0;
        else if (nx > X_MAX) nx = X_MAX;
        if (ny < 0) ny = 0;
        else if (ny > Y_MAX) ny = Y_MAX;
        moved = (nx != int'(x_pos)) || (ny != int'(y_pos));
    end

    always_ff @(posedge clock) begin
        if (reset || init) begin
            x_pos     <= 9'(START_X);
            y_pos     <= 8'(START_Y);
            facing    <= F_DOWN;
            direction <= DIR_NONE;
            anim      <= 1'b0;
            move_cnt  <= '0;
            atk_cnt   <= '0;
            hurt_cnt  <= '0;
        end else if (reg_action) begin
            if (c_attack)     direction <= DIR_ATTACK;
            else if (c_up)    direction <= DIR_UP;
            else if (c_down)  direction <= DIR_DOWN;
            else if (c_left)  direction <= DIR_LEFT;
            else if (c_right) direction <= DIR_RIGHT;
            else              direction <= DIR_NONE;
        end else if (apply_action) begin
            if (collision[1] && !hurt) hurt_cnt <= HKW'(HURT_TICKS);
            else if (hurt)             hurt_cnt <= hurt_cnt - 1'b1;
            if (attacking)
                atk_cnt <= atk_cnt - 1'b1;
            else if (direction == DIR_ATTACK)
                atk_cnt <= AKW'(ATTACK_TICKS);
            else begin
                // NONE falls through harmlessly: candidate equals current state.
                facing <= nface;
                x_pos  <= nx[8:0];
                y_pos  <= ny[7:0];
                if (moved) begin
                    if (move_cnt == MW'(ANIM_DIV - 1)) begin
                        move_cnt <= '0;
                        anim     <= ~anim;
                    end else begin
                        move_cnt <= move_cnt + 1'b1;
                    end
                end
            end
        end
    end

    // No pixel is issued on the done cycle so a strobe still held there does not restart.
    assign issue       = draw && !init && !reg_action && !apply_action && !draw_done;
    assign last_pix    = (pix == PW'(NPIX - 1));
    assign sprite_addr = {attacking, facing, anim, pix};

    always_ff @(posedge clock) begin
        if (reset || init) begin
            pix       <= '0;
            pix_vld   <= 1'b0;
            draw_done <= 1'b0;
            x_draw    <= '0;
            y_draw    <= '0;
        end else begin
            pix_vld   <= issue;
            draw_done <= issue && last_pix;
            if (issue) begin
                pix    <= last_pix ? '0 : pix + 1'b1;
                x_draw <= x_pos + 9'(pix[XW-1:0]);
                y_draw <= y_pos + 8'(pix[PW-1:XW]);
            end
        end
    end

    assign colour    = sprite_q;
    assign VGA_write = pix_vld && (sprite_q != TRANSPARENT) && !(hurt && hurt_cnt[2]);
endmodule
